// File: rtl/seq_mult_32_pkg.sv
// seq_mult_32_pkg: miniRISC common definitions shared by the decoder, ALU and multiplier.
package seq_mult_32_pkg;
    localparam int WORD_W = 32;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_MUL = 3'b000;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mul_state_t;
endpackage

// File: rtl/seq_mult_32_if.sv
// seq_mult_32_if: issue/writeback handshake bundle between the decoder/ALU, the multiplier and writeback.
interface seq_mult_32_if
    import seq_mult_32_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             ovf;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, prod_hi, prod_lo, ovf);
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, prod_hi, prod_lo, ovf);
endinterface

// File: rtl/seq_mult_32_adder.sv
// adder_32_bit: the execute stage's 32-bit adder, reused by the multiplier each iteration.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

// File: rtl/seq_mult_32.sv
// seq_mult_32: unsigned 32x32->64 shift-and-add multiplier, one adder pass per multiplier bit.
// SEQ_MULT_EARLY_ZERO_EN: a zero operand skips the iterations and completes on the accept edge.
module seq_mult_32
    import seq_mult_32_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    seq_mult_32_if.slave mul_io
);
    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    adder_32_bit u_add (
        .a    (acc_hi_q),
        .b    (acc_lo_q[0] ? mcand_q : '0),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(c_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (mul_io.in_valid) begin
                mcand_d  = mul_io.a;
                acc_hi_d = '0;
                acc_lo_d = mul_io.b;
                cnt_d    = '0;
                state_d  = RUN;
`ifdef SEQ_MULT_EARLY_ZERO_EN
                if (mul_io.a == '0 || mul_io.b == '0) begin
                    acc_lo_d = '0;
                    state_d  = DONE;
                end
`endif
            end
            RUN: begin
                // Shift the carry-extended partial sum right; product bits enter acc_lo from the top.
                {acc_hi_d, acc_lo_d} = {c_out, sum, acc_lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE: state_d = mul_io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Product registers double as the result holding registers after returning to IDLE.
    assign mul_io.in_ready  = (state_q == IDLE);
    assign mul_io.out_valid = (state_q == DONE);
    assign mul_io.prod_hi   = acc_hi_q;
    assign mul_io.prod_lo   = acc_lo_q;
    assign mul_io.ovf       = |acc_hi_q;
endmodule

// File: tb/tb_seq_mult_32.sv
// tb_seq_mult_32: directed vectors with a queued scoreboard checked by an independent output monitor.
module tb_seq_mult_32;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    seq_mult_32_if bus ();
    seq_mult_32 dut (.clk(clk), .rst(rst), .mul_io(bus));

`ifdef SEQ_MULT_EARLY_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, 65'(bus.in_ready), 65'd1);
        chk({nm, "_out_valid"}, 65'(bus.out_valid), 65'd0);
        chk({nm, "_prod"}, {bus.ovf, bus.prod_hi, bus.prod_lo}, 65'd0);
    endtask

    // Monitor: every cycle the DUT shows a result it must equal the queue head; the head retires on handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {bus.ovf, bus.prod_hi, bus.prod_lo}, 65'h1_dead_beef_dead_beef);
            end else begin
                chk("product", {bus.ovf, bus.prod_hi, bus.prod_lo}, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 65'd0, 65'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int n = 1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (lat > 0) chk({nm, "_latency"}, 65'(n), 65'(lat));
        else if (!bus.out_valid) chk({nm, "_valid_timeout"}, 65'd0, 65'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (bus.out_valid) chk("drain_timeout", 65'd1, 65'd0);
    endtask

    task automatic issue(input string nm, input logic [31:0] ai, input logic [31:0] bi,
                         input logic [64:0] exp, input int lat);
        exp_q.push_back(exp);
        bus.a = ai; bus.b = bi; bus.in_valid = 1'b1;
        wait_accept();
        wait_valid(nm, lat);
        wait_drain();
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        #3 rst = 1'b1;
        #1 chk_reset_vals("reset");
        #7 rst = 1'b0;
        @(posedge clk); #1;
        issue("8x12", 32'd8, 32'd12, {1'b0, 64'd96}, 33);
        issue("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b1, 64'hFFFF_FFFE_0000_0001}, 33);
        // Stalled consumer; a second request arrives while the first result is held.
        bus.out_ready = 1'b0;
        exp_q.push_back({1'b1, 64'h0000_0001_0000_0000});
        bus.a = 32'h8000_0000; bus.b = 32'd2; bus.in_valid = 1'b1;
        wait_accept();
        wait_valid("stall", 33);
        exp_q.push_back({1'b0, 64'd15});
        bus.a = 32'd3; bus.b = 32'd5; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("done_in_ready", 65'(bus.in_ready), 65'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_handshake_valid", 65'(bus.out_valid), 65'd0);
        wait_accept();
        wait_valid("3x5", 33);
        wait_drain();
        // Abort a multiply partway through with an asynchronous reset.
        bus.a = 32'd7; bus.b = 32'd9; bus.in_valid = 1'b1;
        wait_accept();
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_vals("midrun_reset");
        #3 rst = 1'b0;
        @(posedge clk); #1;
        issue("7x9", 32'd7, 32'd9, {1'b0, 64'd63}, 33);
        issue("0x1234", 32'd0, 32'd1234, {1'b0, 64'd0}, ZERO_LAT);
        issue("5x0", 32'd5, 32'd0, {1'b0, 64'd0}, ZERO_LAT);
        repeat (3) @(posedge clk);
        chk("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
